// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared 16-bit barrel shifter (SLL/SRA/ROR).
// The result lands in a single-entry response slot; contention cycles feed a saturating counter.
module shift_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_data,
  input  logic [3:0]       req0_shamt,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_data,
  input  logic [3:0]       req1_shamt,
  input  logic [1:0]       req1_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_id_q, rsp_id_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic        both_valid;
  logic        can_accept;
  logic        grant_id;
  logic        xfer;
  logic [15:0] op_data;
  logic [3:0]  op_shamt;
  logic [1:0]  op_mode;
  logic [15:0] shift_res;

  always_comb begin
    both_valid = req0_valid && req1_valid;
    can_accept = !rsp_valid_q || rsp_ready;
    if (both_valid) grant_id = RR_EN ? !last_grant_q : 1'b0;
    else            grant_id = req1_valid;
    req0_ready = !rst && can_accept && req0_valid && !grant_id;
    req1_ready = !rst && can_accept && req1_valid && grant_id;
    xfer       = req0_ready || req1_ready;
    op_data    = grant_id ? req1_data  : req0_data;
    op_shamt   = grant_id ? req1_shamt : req0_shamt;
    op_mode    = grant_id ? req1_mode  : req0_mode;
  end

  // Log-stage barrel: stage i moves by 2**i when shamt bit i is set.
  always_comb begin
    logic [15:0] stage;
    logic [15:0] sign_fill;
    stage     = op_data;
    sign_fill = {16{op_data[15]}};
    for (int i = 0; i < 4; i++) begin
      int sh;
      sh = 1 << i;
      if (op_shamt[i]) begin
        case (op_mode)
          MODE_SLL: stage = stage << sh;
          MODE_SRA: stage = (stage >> sh) | (sign_fill & ~(16'hFFFF >> sh));
          MODE_ROR: stage = (stage >> sh) | (stage << (16 - sh));
          default:  stage = stage;
        endcase
      end
    end
    shift_res = (op_mode == 2'b11) ? 16'h0000 : stage;
  end

  always_comb begin
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_id_d       = rsp_id_q;
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;
    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_data_d   = shift_res;
      rsp_zero_d   = (shift_res == 16'h0000);
      rsp_id_d     = grant_id;
      last_grant_d = grant_id;
      if (both_valid && !(&conflict_cnt_q)) conflict_cnt_d = conflict_cnt_q + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 16'h0000;
      rsp_zero_q     <= 1'b0;
      rsp_id_q       <= 1'b0;
      last_grant_q   <= 1'b1;
      conflict_cnt_q <= '0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_id_q       <= rsp_id_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_id       = rsp_id_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
